// File: rtl/tff_mod_updown_counter.sv
// Synchronous N-bit up/down counter with runtime modulus, parallel load,
// wrap-or-saturate boundary handling and terminal-count / wrap / overflow flags.
// General-purpose event/timer counter; every register sits on clk.
module tff_mod_updown_counter #(
    parameter int WIDTH       = 8,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap_pulse,
    output logic             ovf_sticky
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VALUE);
    localparam bit               DO_WRAP = (SATURATE == 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_bound;
    logic             bound_evt;

    // Boundary detect, next-count selection and flag next-state.
    always_comb begin
        // Up counting treats anything at or above max_val as the boundary, so a
        // count stranded above a freshly lowered max_val wraps/saturates at once.
        at_bound  = up_down ? (count_q >= max_val) : (count_q == '0);
        // Load has priority over counting, so a load cycle is never a boundary event.
        bound_evt = en & ~load & at_bound;
        count_d   = count_q;

        if (load) begin
            count_d = (load_val > max_val) ? max_val : load_val;
        end else if (en) begin
            if (at_bound) begin
                if (DO_WRAP) begin
                    count_d = up_down ? '0 : max_val;
                end
            end else if (up_down) begin
                count_d = count_q + WIDTH'(1);
            end else if (count_q > max_val) begin
                // Re-enter the legal range after max_val was lowered.
                count_d = max_val;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end

        wrap_d = bound_evt & DO_WRAP;
        // Set wins over a coincident clear.
        ovf_d  = bound_evt | (ovf_q & ~clr_ovf);
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RST_CNT;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count      = count_q;
    assign tc         = bound_evt;
    assign wrap_pulse = wrap_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_tff_mod_updown_counter.sv
// Directed bench: a wrapping instance (RESET_VALUE 0) driven from a vector table,
// and a saturating instance (RESET_VALUE 3) plus async-reset corner cases by hand.
module tb_tff_mod_updown_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, up_down, load, clr_ovf;
    logic [W-1:0] load_val, max_val;

    logic [W-1:0] cnt_w, cnt_s;
    logic         tc_w, tc_s, wp_w, wp_s, ovf_w, ovf_s;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         en;
        logic         ud;
        logic         ld;
        logic [W-1:0] lv;
        logic [W-1:0] mv;
        logic         clr;
        logic         etc;   // tc expected before the edge
        logic [W-1:0] ecnt;  // values expected after the edge
        logic         ewp;
        logic         eovf;
    } vec_t;

    vec_t tbl[$];

    tff_mod_updown_counter #(.WIDTH(W), .SATURATE(0), .RESET_VALUE(0)) u_w (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
        .count(cnt_w), .tc(tc_w), .wrap_pulse(wp_w), .ovf_sticky(ovf_w));

    tff_mod_updown_counter #(.WIDTH(W), .SATURATE(1), .RESET_VALUE(3)) u_s (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
        .count(cnt_s), .tc(tc_s), .wrap_pulse(wp_s), .ovf_sticky(ovf_s));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic ud, input logic ld, input int lv,
                       input int mv, input logic clr, input logic etc, input int ecnt,
                       input logic ewp, input logic eovf);
        vec_t v;
        v.en = e; v.ud = ud; v.ld = ld; v.lv = W'(lv); v.mv = W'(mv); v.clr = clr;
        v.etc = etc; v.ecnt = W'(ecnt); v.ewp = ewp; v.eovf = eovf;
        tbl.push_back(v);
    endtask

    // Drive one vector after the falling edge, check tc before the rising edge,
    // check registered outputs just after it. which: 0 = wrap DUT, 1 = sat DUT.
    task automatic step(input vec_t v, input int which, input string name);
        @(negedge clk);
        en = v.en; up_down = v.ud; load = v.ld; load_val = v.lv;
        max_val = v.mv; clr_ovf = v.clr;
        #1;
        chk({name, ".tc"}, which ? tc_s : tc_w, v.etc);
        @(posedge clk);
        #1;
        chk({name, ".count"}, which ? cnt_s : cnt_w, v.ecnt);
        chk({name, ".wrap"},  which ? wp_s  : wp_w,  v.ewp);
        chk({name, ".ovf"},   which ? ovf_s : ovf_w, v.eovf);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        en = 0; load = 0; clr_ovf = 0;
        reset = 1;
        #2 reset = 0;
    endtask

    initial begin
        vec_t v;
        reset = 1; en = 0; up_down = 1; load = 0; clr_ovf = 0;
        load_val = '0; max_val = 4'd9;

        // Wrap instance, max 9, up from reset: 0..9 then 0.
        for (int i = 0; i < 10; i++)
            add(1, 1, 0, 0, 9, 0, (i == 9), (i + 1) % 10, (i == 9), (i == 9));
        add(1, 1, 0, 0, 9, 0, 0, 1, 0, 1);
        // Down from load 2: 2,1,0,9,8.
        add(1, 0, 1, 2, 9, 0, 0, 2, 0, 1);
        add(0, 0, 0, 0, 9, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 9, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 9, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 9, 0, 1, 9, 1, 1);
        add(1, 0, 0, 0, 9, 0, 0, 8, 0, 1);
        // Clamped load with en high, ovf untouched; then in-range load.
        add(0, 1, 0, 0, 9, 1, 0, 8, 0, 0);
        add(1, 1, 1, 12, 9, 0, 0, 9, 0, 0);
        add(1, 1, 1, 3, 9, 0, 0, 3, 0, 0);
        for (int i = 3; i < 8; i++)
            add(1, 1, 0, 0, 9, 0, 0, i + 1, 0, 0);
        // At 8, lower max to 4 counting up: wraps to 0.
        add(1, 1, 0, 0, 4, 0, 1, 0, 1, 1);
        // Down-mode re-entry: load 8 under max 9, then max 4 down -> 4.
        add(0, 0, 1, 8, 9, 0, 0, 8, 0, 1);
        add(1, 0, 0, 0, 4, 0, 0, 4, 0, 1);
        // Clear coincident with a boundary event: set wins.
        add(1, 1, 0, 0, 4, 1, 1, 0, 1, 1);
        // max_val = 0: every enabled cycle is a boundary.
        add(1, 1, 0, 0, 0, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);

        #12;
        chk("rst.w.count", cnt_w, 0);
        chk("rst.w.wrap",  wp_w,  0);
        chk("rst.w.ovf",   ovf_w, 0);
        chk("rst.s.count", cnt_s, 3);
        @(negedge clk);
        reset = 0;

        foreach (tbl[i]) step(tbl[i], 0, $sformatf("vec%0d", i));

        // Async reset mid-cycle at count 7 with ovf set.
        v.clr = 0; v.lv = 9; v.mv = 9; v.ud = 1;
        v.en = 0; v.ld = 1; v.etc = 0; v.ecnt = 9; v.ewp = 0; v.eovf = 0;
        step(v, 0, "ar.load9");
        v.en = 1; v.ld = 0; v.etc = 1; v.ecnt = 0; v.ewp = 1; v.eovf = 1;
        step(v, 0, "ar.wrap");
        v.en = 0; v.ld = 1; v.lv = 7; v.etc = 0; v.ecnt = 7; v.ewp = 0; v.eovf = 1;
        step(v, 0, "ar.load7");
        @(negedge clk);
        en = 0; load = 0;
        #2 reset = 1;
        #1;
        chk("ar.count", cnt_w, 0);
        chk("ar.wrap",  wp_w,  0);
        chk("ar.ovf",   ovf_w, 0);
        #1 reset = 0; en = 1; up_down = 1;
        @(posedge clk);
        #1;
        chk("ar.resume", cnt_w, 1);

        // Saturating instance, max 5, up 10 cycles from reset value 3.
        pulse_reset();
        #1;
        chk("sat.rst", cnt_s, 3);
        v.ld = 0; v.lv = 0; v.mv = 5; v.clr = 0; v.en = 1; v.ud = 1; v.ewp = 0;
        for (int i = 0; i < 10; i++) begin
            v.etc  = (3 + i >= 5);
            v.ecnt = W'((4 + i > 5) ? 5 : 4 + i);
            v.eovf = (3 + i >= 5);
            step(v, 1, $sformatf("sat.up%0d", i));
        end
        v.ud = 0;
        for (int i = 0; i < 5; i++) begin
            v.etc = 0; v.ecnt = W'(4 - i); v.eovf = 1;
            step(v, 1, $sformatf("sat.dn%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            v.etc = 1; v.ecnt = 0; v.eovf = 1;
            step(v, 1, $sformatf("sat.hold%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
